// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: shared opcodes, FSM states, ALU modes and instruction field positions
package regfile_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDI  = 3'b001,
        OP_MOV  = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_SWAP = 3'b101,
        OP_OUT  = 3'b110,
        OP_ILL  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SWAP2 = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2
    } alu_op_e;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 5;
    localparam int RD_BIT  = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;
    localparam int RA_BIT  = 1;
    localparam int RB_BIT  = 0;

endpackage

// File: rtl/regfile_sequencer_alu4.sv
// alu4: combinational pass/add/subtract with carry-out or borrow
module alu4
    import regfile_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  alu_op_e      op_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] y_o,
    output logic         c_o
);

    logic [N:0] s;

    // one extra bit: carry for add, borrow (a < b) for subtract, zero for pass
    always_comb begin
        s   = (op_i == ALU_ADD) ? {1'b0, a_i} + {1'b0, b_i} :
              (op_i == ALU_SUB) ? {1'b0, a_i} - {1'b0, b_i} : {1'b0, a_i};
        y_o = s[N-1:0];
        c_o = s[N];
    end

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: decodes 8-bit micro-instructions and drives a 2-entry register file
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_instr,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         rf_SA,
    output logic         rf_SB,
    output logic         rf_DA,
    output logic         rf_W,
    output logic [N-1:0] rf_D,
    input  logic [N-1:0] rf_A,
    input  logic [N-1:0] rf_B,
    output logic         done,
    output logic [N-1:0] result,
    output logic         flag_z,
    output logic         flag_c,
    output logic         err
);

    state_e       state_q, state_d;
    logic [7:0]   ir_q, ir_d;
    logic [N-1:0] tmp_q, tmp_d;
    logic [N-1:0] result_q, result_d;
    logic         z_q, z_d, c_q, c_d, err_q, err_d;

    opcode_e      op;
    logic         rd, ra, rb;
    logic [N-1:0] imm, alu_a, alu_y;
    logic         alu_c;
    alu_op_e      alu_op;

    assign op     = opcode_e'(ir_q[OP_MSB:OP_LSB]);
    assign rd     = ir_q[RD_BIT];
    assign ra     = ir_q[RA_BIT];
    assign rb     = ir_q[RB_BIT];
    assign imm    = N'(ir_q[IMM_MSB:IMM_LSB]);
    assign alu_a  = (op == OP_LDI) ? imm : rf_A;
    assign alu_op = (op == OP_ADD) ? ALU_ADD : (op == OP_SUB) ? ALU_SUB : ALU_PASS;

    alu4 #(.N(N)) u_alu (
        .op_i (alu_op),
        .a_i  (alu_a),
        .b_i  (rf_B),
        .y_o  (alu_y),
        .c_o  (alu_c)
    );

    assign result = result_q;
    assign flag_z = z_q;
    assign flag_c = c_q;
    assign err    = err_q;

    // next-state, register-file strobes and retire values for the current instruction
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        tmp_d    = tmp_q;
        result_d = result_q;
        z_d      = z_q;
        c_d      = c_q;
        err_d    = err_q;
        in_ready = 1'b0;
        rf_SA    = 1'b0;
        rf_SB    = 1'b0;
        rf_DA    = 1'b0;
        rf_W     = 1'b0;
        rf_D     = '0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ir_d    = in_instr;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rf_SA   = ra;
                rf_SB   = rb;
                rf_DA   = rd;
                rf_D    = alu_y;
                state_d = S_DONE;
                case (op)
                    OP_LDI, OP_MOV: begin
                        rf_W     = 1'b1;
                        result_d = alu_y;
                    end
                    OP_ADD, OP_SUB: begin
                        rf_W     = 1'b1;
                        result_d = alu_y;
                        z_d      = (alu_y == '0);
                        c_d      = alu_c;
                    end
                    OP_SWAP: begin
                        rf_SA    = 1'b1;
                        rf_SB    = 1'b0;
                        rf_DA    = 1'b0;
                        rf_D     = rf_A;
                        rf_W     = 1'b1;
                        tmp_d    = rf_B;
                        result_d = rf_A;
                        state_d  = S_SWAP2;
                    end
                    OP_OUT:  result_d = rf_A;
                    OP_ILL:  err_d = 1'b1;
                    default: ;
                endcase
            end
            S_SWAP2: begin
                rf_DA   = 1'b1;
                rf_D    = tmp_q;
                rf_W    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers; reset returns everything to idle defaults
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ir_q     <= '0;
            tmp_q    <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            tmp_q    <= tmp_d;
            result_q <= result_d;
            z_q      <= z_d;
            c_q      <= c_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: directed instruction stream checked against a per-instruction model
module tb_regfile_sequencer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_instr = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, rf_SA, rf_SB, rf_DA, rf_W, done, flag_z, flag_c, err;
    logic [N-1:0] rf_D, rf_A, rf_B, result;

    logic [N-1:0] mem [2];

    regfile_sequencer #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_instr (in_instr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rf_SA    (rf_SA),
        .rf_SB    (rf_SB),
        .rf_DA    (rf_DA),
        .rf_W     (rf_W),
        .rf_D     (rf_D),
        .rf_A     (rf_A),
        .rf_B     (rf_B),
        .done     (done),
        .result   (result),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .err      (err)
    );

    always #5 clk = ~clk;

    assign rf_A = mem[rf_SA];
    assign rf_B = mem[rf_SB];

    // environment register file, written on the clock edge when rf_W is high
    always @(posedge clk) if (rf_W) mem[rf_DA] <= rf_D;

    int n_checks = 0;
    int n_err    = 0;

    logic [3:0] m_r [2];
    logic [3:0] m_res = '0;
    logic       m_z = 1'b0, m_c = 1'b0, m_err = 1'b0;

    logic       chk_en = 1'b0;
    logic       e_ready = 1'b1, e_w = 1'b0, e_da = 1'b0, e_done = 1'b0, e_rchk = 1'b1;
    logic [3:0] e_d = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        e_ready = 1'b1;
        e_w     = 1'b0;
        e_done  = 1'b0;
        e_rchk  = 1'b1;
    endtask

    // per-cycle comparison of all meaningful outputs against the model expectations
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, e_ready);
            chk("rf_W", rf_W, e_w);
            if (e_w) begin
                chk("rf_DA", rf_DA, e_da);
                chk("rf_D", rf_D, e_d);
            end
            chk("done", done, e_done);
            if (e_rchk) begin
                chk("result", result, m_res);
                chk("flag_z", flag_z, m_z);
                chk("flag_c", flag_c, m_c);
            end
            chk("err", err, m_err);
            if (e_ready) chk("idle_outputs", {rf_SA, rf_SB, rf_DA, rf_D}, 0);
        end
    end

    task automatic run(input logic [7:0] ins);
        logic [2:0] op;
        logic       rd, ra, rb, z, c, er;
        logic [4:0] s;
        logic [3:0] res;
        logic       wa [2];
        logic [3:0] wd [2];
        int         nw;
        op = ins[7:5]; rd = ins[4]; ra = ins[1]; rb = ins[0];
        nw = 0; res = m_res; z = m_z; c = m_c; er = m_err;
        wa[0] = 1'b0; wa[1] = 1'b0; wd[0] = '0; wd[1] = '0;
        case (op)
            3'd1: begin nw = 1; wa[0] = rd; wd[0] = ins[3:0]; res = wd[0]; end
            3'd2: begin nw = 1; wa[0] = rd; wd[0] = m_r[ra]; res = wd[0]; end
            3'd3: begin
                s = {1'b0, m_r[ra]} + {1'b0, m_r[rb]};
                nw = 1; wa[0] = rd; wd[0] = s[3:0]; res = s[3:0];
                z = (s[3:0] == 0); c = s[4];
            end
            3'd4: begin
                nw = 1; wa[0] = rd; wd[0] = m_r[ra] - m_r[rb]; res = wd[0];
                z = (wd[0] == 0); c = (m_r[ra] < m_r[rb]);
            end
            3'd5: begin
                nw = 2; wa[0] = 1'b0; wd[0] = m_r[1]; wa[1] = 1'b1; wd[1] = m_r[0]; res = m_r[1];
            end
            3'd6: res = m_r[ra];
            3'd7: er = 1'b1;
            default: ;
        endcase
        in_instr = ins;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e_ready = 1'b0; e_rchk = 1'b1; e_w = (nw > 0); e_da = wa[0]; e_d = wd[0];
        if (nw == 2) begin
            @(posedge clk); #1;
            e_w = 1'b1; e_da = wa[1]; e_d = wd[1]; e_rchk = 1'b0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < nw; i++) m_r[wa[i]] = wd[i];
        m_res = res; m_z = z; m_c = c; m_err = er;
        e_w = 1'b0; e_done = 1'b1; e_rchk = 1'b1;
        @(posedge clk); #1;
        set_idle();
        chk("rf_r0", mem[0], m_r[0]);
        chk("rf_r1", mem[1], m_r[1]);
    endtask

    initial begin
        mem[0] = '0; mem[1] = '0;
        m_r[0] = '0; m_r[1] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_idle();
        chk_en = 1'b1;
        chk("rst_ready", in_ready, 1);
        chk("rst_result", result, 0);
        @(posedge clk); #1;

        run(8'h25);
        chk("lit_ldi5", result, 5);
        run(8'h33);
        chk("lit_ldi3", result, 3);
        run(8'h61);
        chk("lit_add8", {result, flag_z, flag_c}, {4'd8, 1'b0, 1'b0});
        run(8'h92);
        chk("lit_subB", {result, flag_z, flag_c}, {4'hB, 1'b0, 1'b1});
        run(8'h29);
        run(8'h37);
        run(8'h61);
        chk("lit_add_wrap", {result, flag_z, flag_c}, {4'd0, 1'b1, 1'b1});
        run(8'hC0);
        chk("lit_out_r0", result, 0);
        run(8'hC2);
        chk("lit_out_r1", result, 7);
        run(8'h42);
        run(8'h00);
        chk("lit_nop_hold", result, 7);
        run(8'h22);
        run(8'h36);
        run(8'hA0);
        chk("lit_swap", {result, mem[0], mem[1]}, {4'd6, 4'd6, 4'd2});
        run(8'hE0);
        chk("lit_ill_err", err, 1);
        run(8'h21);
        chk("lit_err_sticky", err, 1);

        in_instr = 8'hA0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e_ready = 1'b0; e_rchk = 1'b1; e_w = 1'b1; e_da = 1'b0; e_d = m_r[1];
        @(posedge clk); #1;
        e_w = 1'b1; e_da = 1'b1; e_d = m_r[0]; e_rchk = 1'b0;
        rst = 1'b1; in_valid = 1'b1; in_instr = 8'h25;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        {m_r[0], m_r[1]} = {m_r[1], m_r[0]};
        m_res = '0; m_z = 1'b0; m_c = 1'b0; m_err = 1'b0;
        set_idle();
        @(posedge clk); #1;
        chk("lit_rst_rf", {mem[0], mem[1]}, {4'd2, 4'd1});
        chk("lit_rst_err", err, 0);
        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
